// File: rtl/alu_op_issuer.sv
// Clocked valid/ready driver for the Dinter ALU operand interface: issues A/B/sel,
// waits SETTLE cycles, captures out. Optional result checker under ALU_ISSUE_CHECK_EN.
module alu_op_issuer #(
  parameter int unsigned N      = 8,
  parameter int unsigned M      = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [2:0]   req_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [M-1:0] alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [M-1:0] rsp_data,
  output logic [2:0]   rsp_sel,
  output logic         busy,
  output logic [15:0]  op_count,
  output logic         err
);

  // A settle time of 0 is treated as 1 so the capture always follows the drive edge.
  localparam int unsigned SettleEff = (SETTLE == 0) ? 1 : SETTLE;
  localparam int unsigned CntW      = (SettleEff > 1) ? $clog2(SettleEff) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleEff - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            capture;

  assign capture = (state_q == StWait) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_sel   <= req_sel;
            cnt_q     <= CntLoad;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (capture) begin
            rsp_data  <= alu_out;
            rsp_sel   <= alu_sel;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            op_count  <= op_count + 16'd1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  // Every sel code of the attached ALU selects addition, so the check ignores sel.
  logic [N-1:0] sum_n;
  logic [M-1:0] exp_out;
  logic         err_q;

  assign sum_n   = alu_a + alu_b;
  assign exp_out = M'(sum_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture && (alu_out != exp_out)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
